// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants for the PS/2 keyboard tracker:
// scan-code prefixes, ignore list, decoder states, key indices.
package dino_kbd_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_OVF0   = 8'h00;
  localparam logic [7:0] PS2_OVF1   = 8'hFF;

  localparam logic [8:0] KEY_SPACE  = 9'h029;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    D_IDLE    = 3'd0,
    D_EXT     = 3'd1,
    D_BRK     = 3'd2,
    D_EXT_BRK = 3'd3,
    D_PAUSE   = 3'd4
  } dec_state_e;

  function automatic logic is_ignored(
    input logic [7:0] b
  );
    return (b == PS2_BAT_OK) || (b == PS2_ACK)
        || (b == PS2_RESEND) || (b == PS2_ECHO)
        || (b == PS2_OVF0)   || (b == PS2_OVF1);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// PS/2 pins plus key-state results of the tracker.
// master = keyboard/pin side, slave = tracker.
interface ps2_key_tracker_if;
  logic         ps2_clk;
  logic         ps2_data;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key_down, last_change,
    input  key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_down, last_change,
    output key_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_tracker_frame_rx.sv
// PS/2 frame receiver: sync, clock debounce, 11-bit
// shift, start/parity/stop check and inter-edge timeout.
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          fall, din, frame_ok;

  assign din = dat_sync_q[1];
  assign fall = filt_q & ~filt_d;
  // sh_q[0]=start, [8:1]=data, [9]=parity; din is stop
  assign frame_ok = ~sh_q[0] & din & (^sh_q[9:1]);

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1))
        filt_d = clk_sync_q[1];
      else
        fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    to_d      = to_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = '0;
        if (frame_ok) begin
          valid_d = 1'b1;
          byte_d  = sh_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        sh_d      = {din, sh_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d     = 1'b1;
        bit_cnt_d = '0;
        to_d      = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  // Idle PS/2 lines are high; reset that way to avoid a false edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      to_q       <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      to_q       <= to_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: scan-code set 2 decoder that
// maintains a 512-bit {ext,code} key-held map.
module ps2_key_tracker
  import dino_kbd_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic               pclk,
  input  logic               rst,
  ps2_key_tracker_if.slave   bus
);

  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_err;
  dec_state_e   state_q, state_d;
  logic [2:0]   skip_q, skip_d;
  logic         ev_make, ev_brk;
  logic [8:0]   ev_idx;
  logic [511:0] kd_q, kd_d;
  logic [8:0]   lc_q, lc_d;
  logic         kv_q, kv_d;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .pclk         (pclk),
    .rst          (rst),
    .ps2_clk_i    (bus.ps2_clk),
    .ps2_data_i   (bus.ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (rx_valid) begin
      case (state_q)
        D_IDLE: begin
          unique case (1'b1)
            (rx_byte == PS2_EXT): state_d = D_EXT;
            (rx_byte == PS2_BRK): state_d = D_BRK;
            (rx_byte == PS2_PAUSE): begin
              state_d = D_PAUSE;
              skip_d  = PAUSE_SKIP;
            end
            default: ;
          endcase
        end
        D_EXT: begin
          if (rx_byte == PS2_BRK)
            state_d = D_EXT_BRK;
          else if (rx_byte != PS2_EXT)
            state_d = D_IDLE;
        end
        D_BRK: begin
          if (rx_byte == PS2_EXT)
            state_d = D_EXT_BRK;
          else
            state_d = D_IDLE;
        end
        D_EXT_BRK: state_d = D_IDLE;
        D_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1)
            state_d = D_IDLE;
        end
        default: state_d = D_IDLE;
      endcase
    end
  end

  always_comb begin
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_idx  = '0;
    if (rx_valid) begin
      case (state_q)
        D_IDLE: begin
          if (rx_byte != PS2_EXT && rx_byte != PS2_BRK
              && rx_byte != PS2_PAUSE
              && !is_ignored(rx_byte)) begin
            ev_make = 1'b1;
            ev_idx  = {1'b0, rx_byte};
          end
        end
        D_EXT: begin
          if (rx_byte != PS2_BRK && rx_byte != PS2_EXT) begin
            ev_make = 1'b1;
            ev_idx  = {1'b1, rx_byte};
          end
        end
        D_BRK: begin
          if (rx_byte != PS2_EXT) begin
            ev_brk = 1'b1;
            ev_idx = {1'b0, rx_byte};
          end
        end
        D_EXT_BRK: begin
          ev_brk = 1'b1;
          ev_idx = {1'b1, rx_byte};
        end
        default: ;
      endcase
    end
  end

  // Typematic repeats and stray breaks leave state untouched.
  always_comb begin
    kd_d = kd_q;
    lc_d = lc_q;
    kv_d = 1'b0;
    if (ev_make && !kd_q[ev_idx]) begin
      kd_d[ev_idx] = 1'b1;
      lc_d         = ev_idx;
      kv_d         = 1'b1;
    end else if (ev_brk && kd_q[ev_idx]) begin
      kd_d[ev_idx] = 1'b0;
      lc_d         = ev_idx;
      kv_d         = 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      kd_q <= '0;
      lc_q <= '0;
      kv_q <= 1'b0;
    end else begin
      kd_q <= kd_d;
      lc_q <= lc_d;
      kv_q <= kv_d;
    end
  end

  assign bus.key_down    = kd_q;
  assign bus.last_change = lc_q;
  assign bus.key_valid   = kv_q;
  assign bus.frame_err   = rx_err;

endmodule
